sqrt_pipe: RTL
==============

# sqrt_pipe

Parametrised, fully pipelined unsigned integer square root with valid/ready flow control. It accepts one W-bit radicand per cycle and returns floor(sqrt(x)) and the remainder x − root² after a fixed latency. The restoring digit-by-digit algorithm retires 2 radicand bits and 1 root bit per registered stage. It sits in the datapath wherever magnitude or norm values are produced, for example after a sum-of-squares accumulator.

## Interface
Parameters:
- W — 16 — radicand width; must be even and ≥ 4. Root width R = W/2.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  radicand present
- in_ready  out  1  block accepts a radicand this cycle
- in_data  in  W  unsigned radicand
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts the result
- out_root  out  R  root; floor by default, rounded when SQRT_ROUND_EN is defined
- out_rem  out  R+1  floor remainder x − floor_root², range 0..2·floor_root

## Operation
- Pipeline has N = R compute stages, plus one output stage when SQRT_ROUND_EN is defined. Each stage registers valid, the partial root (R bits), the partial remainder (R+2 bits) and the unconsumed radicand bits.
- Stage k, for k = 0..N−1, consumes radicand bits [W−1−2k : W−2−2k]:
  - t = (rem<<2 | bits) − (root<<2 | 1), computed at R+3 bits.
  - If t ≥ 0: rem = t, root = root<<1 | 1.
  - Otherwise: rem = rem<<2 | bits, root = root<<1.
- Stage 0 starts with rem = 0 and root = 0.
- Global enable: en = !out_valid || out_ready. When en = 0, every stage register holds, including invalid bubbles. There is no bubble collapsing.
- in_ready = en && !rst. A transfer occurs when in_valid && in_ready.
- Invalid slots advance when en = 1. Data registers in an invalid slot are don't-care, but out_root and out_rem stay stable while out_valid = 0.
- Reset: all valid bits 0, out_valid 0, out_root 0, out_rem 0, in_ready 0 while rst is high. Reset mid-operation discards all in-flight results. No result from before the reset ever appears.
- Simultaneous accept and output in the same cycle is legal; the pipeline advances by one.
- Boundary values:
  - x = 0 gives root 0, rem 0.
  - x = 2^W−1 gives root 2^R−1, rem 2^(R+1)−2, which uses the full R+1 bits of out_rem.

## Timing
- Latency from accepting transfer to out_valid: N cycles, or N+1 with SQRT_ROUND_EN. This assumes no stall.
- Throughput: one result per cycle while out_ready = 1.
- Stall: if out_ready is low while out_valid is high, out_root, out_rem and out_valid hold, and in_ready drops in that same cycle (combinational from out_ready).
- Outputs are registered. The only combinational paths are out_ready → in_ready and rst → in_ready.

## Configuration
- SQRT_ROUND_EN defined:
  - Adds one output register stage.
  - out_root = floor_root + 1 when rem > floor_root, otherwise floor_root. The result saturates at 2^R−1.
  - out_rem remains the floor remainder.
  - Latency is N+1.
- SQRT_ROUND_EN undefined: out_root is floor_root, latency is N, and no rounding logic exists.

## Structure
- Package sqrt_pkg holds:
  - the stage-count function nstages(W) = W/2;
  - the rounding helper function round_root(root, rem) with its saturation rule;
  - the default-width constant.
- Sub-module sqrt_stage holds one compute stage: the combinational trial subtract plus its registers and enable, parameterised by W and stage index k. sqrt_pipe instantiates N of them with a generate loop and adds the optional round stage and the handshake logic.

## Test plan
All scenarios use W = 16 and out_ready = 1 unless stated.
- Reset then single input 144 → after 8 cycles: out_root 12, out_rem 0; out_valid high for exactly 1 cycle.
- Back-to-back inputs 0, 1, 145, 65535 on consecutive cycles → consecutive outputs (0,0), (1,0), (12,1), (255,510), in order, with no gaps.
- Stall: stream 100, 200, 300, then out_ready low for 5 cycles once 100 reaches the output → (10,0) holds stable and in_ready is low during the stall; after release the outputs are (14,4) then (17,11), with nothing lost or duplicated.
- Reset mid-flight: accept 3 values, assert rst for 1 cycle at cycle 4 → out_valid stays 0 until new inputs propagate, and the old results never appear.
- SQRT_ROUND_EN: inputs 156, 157, 65535 → out_root 12, 13, 255 (the last saturated); out_rem 12, 13, 510; latency 9 cycles.
- Random: 10k random inputs with random out_ready → check root² ≤ x < (root+1)², check rem = x − root², and check order is preserved.

Source files
------------

// File: rtl/sqrt_pkg.sv
// sqrt_pkg: shared width constants and helpers for the pipelined square root.
package sqrt_pkg;
    localparam int W_DEF = 16;

    function automatic int nstages(input int w);
        return w / 2;
    endfunction

    // x >= (root + 0.5)^2 exactly when rem > root; never step past the R-bit maximum
    function automatic logic [31:0] round_root(input logic [31:0] root, input logic [31:0] rem, input int r);
        logic [31:0] max_root;
        max_root = (32'd1 << r) - 32'd1;
        return (rem > root && root != max_root) ? root + 32'd1 : root;
    endfunction
endpackage

// File: rtl/sqrt_stage.sv
// sqrt_stage: one restoring digit stage, retiring radicand bits [W-1-2K : W-2-2K] and one root bit.
module sqrt_stage
    import sqrt_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int K = 0,
    localparam int R = nstages(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         in_valid,
    input  logic [R-1:0] in_root,
    input  logic [R+1:0] in_rem,
    input  logic [W-1:0] in_rad,
    output logic         out_valid,
    output logic [R-1:0] out_root,
    output logic [R+1:0] out_rem,
    output logic [W-1:0] out_rad
);
    logic [R+3:0] cur, trial;
    logic ge;
    logic valid_q, valid_d;
    logic [R-1:0] root_q, root_d;
    logic [R+1:0] rem_q, rem_d;
    logic [W-1:0] rad_q, rad_d;

    // data registers hold across bubbles so the last stage's outputs stay stable while invalid
    always_comb begin
        cur = {in_rem, in_rad[W-1-2*K -: 2]};
        trial = {2'b00, in_root, 2'b01};
        ge = cur >= trial;
        valid_d = in_valid;
        root_d = in_valid ? {in_root[R-2:0], ge} : root_q;
        rem_d = in_valid ? (R+2)'(ge ? cur - trial : cur) : rem_q;
        rad_d = in_valid ? in_rad : rad_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            root_q <= '0;
            rem_q <= '0;
            rad_q <= '0;
        end else if (en) begin
            valid_q <= valid_d;
            root_q <= root_d;
            rem_q <= rem_d;
            rad_q <= rad_d;
        end
    end

    assign out_valid = valid_q;
    assign out_root = root_q;
    assign out_rem = rem_q;
    assign out_rad = rad_q;
endmodule

// File: rtl/sqrt_pipe.sv
// sqrt_pipe: fully pipelined unsigned integer square root with valid/ready flow control.
// Defining SQRT_ROUND_EN adds a registered round-to-nearest output stage.
module sqrt_pipe
    import sqrt_pkg::*;
#(
    parameter int W = W_DEF,
    localparam int R = nstages(W),
    localparam int N = nstages(W)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [R-1:0] out_root,
    output logic [R:0]   out_rem
);
    logic en;
    logic [N:0] v;
    logic [N:0][R-1:0] root;
    logic [N:0][R+1:0] rem;
    logic [N:0][W-1:0] rad;
    logic unused_bits;

    // a single global enable freezes every stage, bubbles included, while the output stalls
    assign en = !out_valid || out_ready;
    assign in_ready = en && !rst;
    assign v[0] = in_valid;
    assign root[0] = '0;
    assign rem[0] = '0;
    assign rad[0] = in_data;

    for (genvar k = 0; k < N; k++) begin : g_stage
        sqrt_stage #(.W(W), .K(k)) u_stage (
            .clk(clk),
            .rst(rst),
            .en(en),
            .in_valid(v[k]),
            .in_root(root[k]),
            .in_rem(rem[k]),
            .in_rad(rad[k]),
            .out_valid(v[k+1]),
            .out_root(root[k+1]),
            .out_rem(rem[k+1]),
            .out_rad(rad[k+1])
        );
    end

    // the final remainder is at most 2*root, so its top bit and the spent radicand are dead
    assign unused_bits = ^{rad[N], rem[N][R+1]};

`ifdef SQRT_ROUND_EN
    logic out_valid_q, out_valid_d;
    logic [R-1:0] out_root_q, out_root_d;
    logic [R:0] out_rem_q, out_rem_d;

    always_comb begin
        out_valid_d = v[N];
        out_root_d = v[N] ? R'(round_root(32'(root[N]), 32'(rem[N]), R)) : out_root_q;
        out_rem_d = v[N] ? rem[N][R:0] : out_rem_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_root_q <= '0;
            out_rem_q <= '0;
        end else if (en) begin
            out_valid_q <= out_valid_d;
            out_root_q <= out_root_d;
            out_rem_q <= out_rem_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_root = out_root_q;
    assign out_rem = out_rem_q;
`else
    assign out_valid = v[N];
    assign out_root = root[N];
    assign out_rem = rem[N][R:0];
`endif
endmodule
